sram_bus_responder: RTL

Responder side of the core's instruction/data request-grant-rvalid bus. It arbitrates the instruction and data ports onto one single-port SRAM with round-robin fairness and generates the per-port grant, response-valid and error signals the core expects. Accesses outside the SRAM window are granted and answered with an error instead of being dropped. It sits between the core and the SRAM, replacing ad-hoc glue logic.

---
 rtl/sram_bus_pkg.sv | 19 +
 rtl/rr_arb2.sv | 38 +++
 rtl/sram_bus_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types and helpers for the SRAM request/grant/rvalid bus responder.
package sram_bus_pkg;

    // Which core port a grant or response belongs to
    typedef enum logic {
        SelInstr = 1'b0,
        SelData  = 1'b1
    } bus_sel_e;

    localparam int unsigned DefaultMemSize = 65536;

    // True when addr falls inside the power-of-two window [start, start+size)
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] start,
                                      input logic [31:0] size);
        return (addr & ~(size - 32'd1)) == start;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, registered priority pointer.
// The pointer only moves on a contested grant, and then to the loser.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // ptr_q == 0 favours req_i[0], ptr_q == 1 favours req_i[1]
    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer update
    always_comb begin
        gnt_o = req_i;
        ptr_d = ptr_q;
        if (req_i == 2'b11) begin
            if (ptr_q == 1'b0) begin
                gnt_o = 2'b01;
                ptr_d = 1'b1;
            end else begin
                gnt_o = 2'b10;
                ptr_d = 1'b0;
            end
        end
    end

    // Pointer register, resets to favour requester 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_bus_responder.sv
// Responder for the core's instruction/data request-grant-rvalid ports.
// Arbitrates both ports onto a single-port SRAM; out-of-window accesses are
// granted and answered with an error one cycle later, never forwarded.
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter int unsigned MemSize  = DefaultMemSize
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                instr_req_i,
    input  logic [31:0]                         instr_addr_i,
    output logic                                instr_gnt_o,
    output logic                                instr_rvalid_o,
    output logic [31:0]                         instr_rdata_o,
    output logic                                instr_err_o,
    input  logic                                data_req_i,
    input  logic                                data_we_i,
    input  logic [3:0]                          data_be_i,
    input  logic [31:0]                         data_addr_i,
    input  logic [31:0]                         data_wdata_i,
    output logic                                data_gnt_o,
    output logic                                data_rvalid_o,
    output logic [31:0]                         data_rdata_o,
    output logic                                data_err_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [3:0]                          mem_be_o,
    output logic [$clog2(MemSize/4)-1:0]        mem_addr_o,
    output logic [31:0]                         mem_wdata_o,
    input  logic [31:0]                         mem_rdata_i
);

    localparam int unsigned MemAw = $clog2(MemSize/4);

    logic [1:0]  gnt;
    logic        any_gnt;
    bus_sel_e    sel;
    logic [31:0] addr_g;
    logic        hit;

    logic        resp_valid_q, resp_valid_d;
    bus_sel_e    resp_sel_q,   resp_sel_d;
    logic        resp_err_q,   resp_err_d;

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  ({data_req_i, instr_req_i}),
        .gnt_o  (gnt)
    );

    assign instr_gnt_o = gnt[0];
    assign data_gnt_o  = gnt[1];

    // Decode the winner's address and drive the SRAM; idle fields stay 0
    always_comb begin
        any_gnt     = |gnt;
        sel         = gnt[1] ? SelData : SelInstr;
        addr_g      = gnt[1] ? data_addr_i : instr_addr_i;
        hit         = addr_hit(addr_g, MemStart, 32'(MemSize));
        mem_req_o   = any_gnt & hit;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            mem_addr_o = addr_g[MemAw+1:2];
            if (sel == SelData) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
            end
        end
    end

    // Next response state follows this cycle's grant
    always_comb begin
        resp_valid_d = any_gnt;
        resp_sel_d   = sel;
        resp_err_d   = any_gnt & ~hit;
    end

    // Response registers: rvalid exactly one cycle after grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_sel_q   <= SelInstr;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_sel_q   <= resp_sel_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Steer the response to its port; rdata is masked on error or no response
    always_comb begin
        instr_rvalid_o = resp_valid_q & (resp_sel_q == SelInstr);
        data_rvalid_o  = resp_valid_q & (resp_sel_q == SelData);
        instr_err_o    = instr_rvalid_o & resp_err_q;
        data_err_o     = data_rvalid_o & resp_err_q;
        instr_rdata_o  = (instr_rvalid_o & ~resp_err_q) ? mem_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o & ~resp_err_q) ? mem_rdata_i : 32'h0;
    end

endmodule
